fifo_rd_stream: RTL and testbench

Read-side drainer for the 512x72 asynchronous link FIFO. It runs in the `rd_clk` domain, drives the FIFO read port (`rd_en`, `rd_data`, `rd_empty`; one-cycle read latency, no output register), and converts the stored 72-bit words into a ready/valid byte-keyed stream. It also checks SOF/EOF framing and keeps frame and error statistics. It sits between the raw 10G receive FIFO and the downstream packet consumer.

---
 rtl/fifo_rd_stream_pkg.sv | 22 ++
 rtl/fifo_rd_stream_skid.sv | 68 ++++++
 rtl/fifo_rd_stream.sv | 135 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream shared definitions
// word layout, framing states, keep decode
package fifo_rd_stream_pkg;

  localparam int CNT_LSB = 64;
  localparam int EOF_BIT = 67;
  localparam int ERR_BIT = 68;
  localparam int SOF_BIT = 69;

  typedef enum logic {
    IDLE  = 1'b0,
    INFRM = 1'b1
  } frm_state_e;

  // byte count minus one -> contiguous low-byte mask
  function automatic logic [7:0] keep_from_cnt(input logic [2:0] cnt);
    logic [7:0] k;
    k = 8'hFF >> (3'd7 - cnt);
    return k;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid.sv
// skid_buf2: two-entry valid/ready buffer
// head drives the output, tail absorbs one extra word
module skid_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int W = 74
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;

  assign valid_o = (occ_q != 2'd0);
  assign data_o  = head_q;
  assign occ_o   = occ_q;
  assign pop     = valid_o & ready_i;

  // next head/tail/occupancy for push, pop or both
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_i, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_data_i;
        else               tail_d = push_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // buffer state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: link FIFO read drainer
// prefetches 72-bit words into a byte-keyed stream, checks framing
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int FIFO_W = 72,
  parameter int FCNT_W = 32,
  parameter int ECNT_W = 16
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  output logic                fifo_rd_en,
  input  logic [FIFO_W-1:0]   fifo_rd_data,
  input  logic                fifo_rd_empty,
  output logic [DATA_W-1:0]   m_data,
  output logic [DATA_W/8-1:0] m_keep,
  output logic                m_last,
  output logic                m_err,
  output logic                m_valid,
  input  logic                m_ready,
  input  logic                clr_stats,
  output logic [FCNT_W-1:0]   frame_cnt,
  output logic [ECNT_W-1:0]   err_cnt,
  output logic                seq_err
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int ENT_W  = DATA_W + KEEP_W + 2;

  logic              inflight_q;
  logic [1:0]        occ;
  logic              pop;
  logic              w_sof, w_eof, w_err;
  logic [2:0]        w_cnt;
  logic [KEEP_W-1:0] w_keep;
  logic [ENT_W-1:0]  w_ent;
  logic [ENT_W-1:0]  head;
  logic              unused_rsv;

  frm_state_e        state_q, state_d;
  logic              seq_err_q, seq_err_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]        err_inc;
  logic [ECNT_W:0]   err_sum;

  assign w_sof  = fifo_rd_data[SOF_BIT];
  assign w_eof  = fifo_rd_data[EOF_BIT];
  assign w_err  = fifo_rd_data[ERR_BIT];
  assign w_cnt  = fifo_rd_data[CNT_LSB +: 3];
  assign w_keep = w_eof ? keep_from_cnt(w_cnt) : '1;
  assign w_ent  = {fifo_rd_data[DATA_W-1:0], w_keep, w_eof, w_err};
  assign unused_rsv = ^fifo_rd_data[FIFO_W-1:SOF_BIT+1];

  assign pop = m_valid & m_ready;

  // a read is only issued when its data is sure to find a free slot
  assign fifo_rd_en = !rd_rst && !fifo_rd_empty &&
    ((({1'b0, occ} + {2'b0, inflight_q} + 3'd1) <= 3'd2) || pop);

  // read latency tracking: data lands the cycle after the read
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) inflight_q <= 1'b0;
    else        inflight_q <= fifo_rd_en;
  end

  skid_buf2 #(
    .W (ENT_W)
  ) u_skid (
    .clk_i       (rd_clk),
    .rst_i       (rd_rst),
    .push_i      (inflight_q),
    .push_data_i (w_ent),
    .ready_i     (m_ready),
    .valid_o     (m_valid),
    .data_o      (head),
    .occ_o       (occ)
  );

  assign {m_data, m_keep, m_last, m_err} = head;

  // framing check on each word as it lands
  always_comb begin
    state_d   = state_q;
    seq_err_d = 1'b0;
    if (inflight_q) begin
      unique case (state_q)
        IDLE:    seq_err_d = !w_sof;
        INFRM:   seq_err_d = w_sof;
        default: seq_err_d = 1'b0;
      endcase
      state_d = w_eof ? IDLE : INFRM;
    end
  end

  // framing state and registered violation pulse
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q   <= IDLE;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_err_q <= seq_err_d;
    end
  end

  // statistics next-state: wrap frames, saturate errors
  always_comb begin
    err_inc     = {1'b0, pop & m_last & m_err} + {1'b0, seq_err_q};
    err_sum     = {1'b0, err_cnt_q} + {{(ECNT_W-1){1'b0}}, err_inc};
    frame_cnt_d = frame_cnt_q + FCNT_W'(pop & m_last);
    err_cnt_d   = err_sum[ECNT_W] ? '1 : err_sum[ECNT_W-1:0];
    if (clr_stats) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end
  end

  // statistics registers
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench
// FIFO model feeds the DUT, a monitor pops expected beats
module tb_fifo_rd_stream;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        fifo_rd_en;
  logic [71:0] fifo_rd_data = '0;
  logic        fifo_rd_empty = 1'b1;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last, m_err, m_valid;
  logic        m_ready = 1'b0;
  logic        clr_stats = 1'b0;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
  logic        seq_err;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .m_data        (m_data),
    .m_keep        (m_keep),
    .m_last        (m_last),
    .m_err         (m_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .clr_stats     (clr_stats),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt),
    .seq_err       (seq_err)
  );

  logic [71:0] fq[$];
  logic [73:0] exp_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int seq_cnt = 0, rd_cnt = 0, vcnt = 0, viol = 0;
  int vfirst = -1, vlast = -1, first_rd = -1, first_v = -1;
  bit take;

  function automatic void chk(string name, logic [127:0] act,
                              logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // FIFO model: one-cycle read latency, empty flag after the pop
  initial forever begin
    @(posedge rd_clk);
    cyc++;
    take = fifo_rd_en;
    #1;
    if (take && fq.size() != 0) fifo_rd_data = fq.pop_front();
    fifo_rd_empty = (fq.size() == 0);
  end

  // monitor: scoreboard compare, stall stability, statistics
  initial begin
    logic [73:0] prev;
    bit stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge rd_clk);
      if (rd_rst) begin
        stall = 1'b0;
      end else begin
        if (fifo_rd_en && fifo_rd_empty) viol++;
        if (fifo_rd_en) begin
          rd_cnt++;
          if (first_rd < 0) first_rd = cyc;
        end
        if (seq_err) seq_cnt++;
        if (m_valid && first_v < 0) first_v = cyc;
        if (stall)
          chk("stall_hold", 128'({m_valid, m_data, m_keep, m_last, m_err}),
              128'({1'b1, prev}));
        if (m_valid && m_ready) begin
          vcnt++;
          if (vfirst < 0) vfirst = cyc;
          vlast = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected: got %0h expected none", m_data);
          end else begin
            chk("beat", 128'({m_data, m_keep, m_last, m_err}),
                128'(exp_q.pop_front()));
          end
        end
        stall = m_valid && !m_ready;
        prev  = {m_data, m_keep, m_last, m_err};
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rd_clk);
      #2;
    end
  endtask

  task automatic push_w(input bit sof, input bit err, input bit eof,
                        input logic [2:0] cnt, input logic [63:0] d);
    logic [71:0] w;
    logic [7:0]  kp;
    w  = {2'b10, sof, err, eof, cnt, d};
    kp = 8'hFF;
    if (eof) begin
      kp = 8'h00;
      for (int b = 0; b < 8; b++)
        if (b <= int'(cnt)) kp[b] = 1'b1;
    end
    fq.push_back(w);
    exp_q.push_back({d, kp, eof, err});
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n;
    n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || m_valid) && n < budget) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
    m_ready = 1'b1;
    tick(2);
  endtask

  initial begin
    int s0;
    tick(2);
    chk("rst_rd_en", 128'(fifo_rd_en), 128'(0));
    chk("rst_valid", 128'(m_valid), 128'(0));
    chk("rst_data", 128'(m_data), 128'(0));
    chk("rst_keep", 128'(m_keep), 128'(0));
    chk("rst_last_err", 128'({m_last, m_err}), 128'(0));
    chk("rst_frame", 128'(frame_cnt), 128'(0));
    chk("rst_errcnt", 128'(err_cnt), 128'(0));
    chk("rst_seq", 128'(seq_err), 128'(0));

    push_w(1'b1, 1'b0, 1'b1, 3'd3, 64'h1122_3344_5566_7788);
    m_ready = 1'b1;
    tick(3);
    chk("rd_en_in_reset", 128'(fifo_rd_en), 128'(0));
    rd_rst = 1'b0;
    drain(20, 1'b0);
    chk("latency", 128'(first_v - first_rd), 128'(2));
    chk("single_frame_cnt", 128'(frame_cnt), 128'(1));
    chk("single_no_seq", 128'(seq_cnt), 128'(0));

    rd_cnt = 0;
    vcnt = 0;
    vfirst = -1;
    vlast = -1;
    for (int i = 0; i < 100; i++)
      push_w(i == 0, 1'b0, i == 99, (i == 99) ? 3'd4 : 3'd2,
             {32'hA000_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)});
    drain(300, 1'b0);
    chk("burst_rd_en_cycles", 128'(rd_cnt), 128'(100));
    chk("burst_beats", 128'(vcnt), 128'(100));
    chk("burst_no_gaps", 128'(vlast - vfirst), 128'(99));
    chk("burst_frame_cnt", 128'(frame_cnt), 128'(2));

    vcnt = 0;
    viol = 0;
    for (int i = 0; i < 100; i++)
      push_w(i == 0, 1'b0, i == 99, (i == 99) ? 3'd0 : 3'd6,
             {32'hC0DE_0000 + 32'(i), ~(32'h1000 + 32'(i))});
    drain(2000, 1'b1);
    chk("rand_beats", 128'(vcnt), 128'(100));
    chk("rand_no_rd_when_empty", 128'(viol), 128'(0));
    chk("rand_frame_cnt", 128'(frame_cnt), 128'(3));

    s0 = seq_cnt;
    push_w(1'b0, 1'b0, 1'b0, 3'd0, 64'hDEAD_0001);
    push_w(1'b1, 1'b0, 1'b0, 3'd0, 64'hDEAD_0002);
    push_w(1'b0, 1'b0, 1'b1, 3'd7, 64'hDEAD_0003);
    drain(50, 1'b0);
    chk("seq_pulses", 128'(seq_cnt - s0), 128'(2));
    chk("seq_errcnt", 128'(err_cnt), 128'(2));
    chk("seq_frame_cnt", 128'(frame_cnt), 128'(4));

    s0 = seq_cnt;
    push_w(1'b0, 1'b1, 1'b1, 3'd5, 64'hBAD0_BAD0);
    drain(50, 1'b0);
    chk("dual_seq", 128'(seq_cnt - s0), 128'(1));
    chk("dual_errcnt", 128'(err_cnt), 128'(4));
    chk("dual_frame_cnt", 128'(frame_cnt), 128'(5));

    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    tick();
    chk("clr_errcnt", 128'(err_cnt), 128'(0));
    chk("clr_frame", 128'(frame_cnt), 128'(0));

    for (int i = 0; i < 32767; i++)
      push_w(1'b0, 1'b1, 1'b1, 3'(i), {32'(i), ~32'(i)});
    drain(40000, 1'b0);
    chk("preload_errcnt", 128'(err_cnt), 128'(16'hFFFE));
    chk("preload_frame", 128'(frame_cnt), 128'(32767));
    push_w(1'b0, 1'b1, 1'b1, 3'd1, 64'h5A7_0001);
    drain(50, 1'b0);
    chk("sat_errcnt", 128'(err_cnt), 128'(16'hFFFF));
    chk("sat_frame", 128'(frame_cnt), 128'(32768));
    push_w(1'b0, 1'b1, 1'b1, 3'd2, 64'h5A7_0002);
    drain(50, 1'b0);
    chk("sat_hold", 128'(err_cnt), 128'(16'hFFFF));

    m_ready = 1'b0;
    push_w(1'b1, 1'b0, 1'b0, 3'd0, 64'h7777_0001);
    push_w(1'b0, 1'b0, 1'b0, 3'd0, 64'h7777_0002);
    push_w(1'b0, 1'b0, 1'b0, 3'd0, 64'h7777_0003);
    tick(6);
    chk("pre_rst_valid", 128'(m_valid), 128'(1));
    rd_rst = 1'b1;
    fq.delete();
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 128'(m_valid), 128'(0));
    chk("mid_rst_rd_en", 128'(fifo_rd_en), 128'(0));
    chk("mid_rst_data", 128'(m_data), 128'(0));
    chk("mid_rst_frame", 128'(frame_cnt), 128'(0));
    chk("mid_rst_errcnt", 128'(err_cnt), 128'(0));
    tick(2);
    rd_rst = 1'b0;
    m_ready = 1'b1;
    s0 = seq_cnt;
    push_w(1'b1, 1'b0, 1'b1, 3'd0, 64'h0123_4567_89AB_CDEF);
    drain(50, 1'b0);
    chk("post_rst_no_seq", 128'(seq_cnt - s0), 128'(0));
    chk("post_rst_frame", 128'(frame_cnt), 128'(1));
    chk("post_rst_errcnt", 128'(err_cnt), 128'(0));
    chk("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
